// File: rtl/sdram_cache_pkg.sv
// Shared types and size helpers for the direct-mapped SDRAM read cache.
// SDRAM widths mirror the sdram_controller defaults.
package sdram_cache_pkg;

  localparam int SDRAM_DATA_BITS = 32;
  localparam int SDRAM_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_WR      = 3'd4,
    S_WAIT_WR = 3'd5,
    S_ACK     = 3'd6
  } state_e;

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  // cpu_addr is one bit narrower than mem_addr (32-bit words on a 16-bit bus)
  function automatic int tag_bits(input int lines, input int addr_bits);
    return addr_bits - 1 - $clog2(lines);
  endfunction

endpackage

// File: rtl/sdram_cache_line_array.sv
// Valid/tag/data storage for the read cache: combinational read by index,
// single write port with byte-enable merge, valid bits clearable in one cycle.
module sdram_cache_line_array #(
  parameter  int LINES     = 64,
  parameter  int DATA_BITS = 32,
  parameter  int TAG_BITS  = 17,
  localparam int IDX_BITS  = $clog2(LINES),
  localparam int BE_BITS   = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_all_i,
  input  logic [IDX_BITS-1:0]  rd_index_i,
  output logic                 rd_valid_o,
  output logic [TAG_BITS-1:0]  rd_tag_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic                 wr_set_valid_i,
  input  logic [IDX_BITS-1:0]  wr_index_i,
  input  logic [TAG_BITS-1:0]  wr_tag_i,
  input  logic [BE_BITS-1:0]   wr_be_i,
  input  logic [DATA_BITS-1:0] wr_data_i
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  // clear_all wins over a same-cycle fill so a flushed line never survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
      for (int b = 0; b < BE_BITS; b++) begin
        if (wr_be_i[b]) data_q[wr_index_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/sdram_read_cache.sv
// Direct-mapped, write-through, one-word-per-line cache in front of sdram_controller.
//   state     | meaning
//   S_IDLE    | waiting for cpu_cs
//   S_LOOKUP  | index the line array, decide hit/miss/write
//   S_MISS    | mem_cs for the refill read
//   S_WAIT_RD | waiting for refill mem_ack, then fill line
//   S_WR      | mem_cs for the forwarded write, merge into line on hit
//   S_WAIT_WR | waiting for write mem_ack
//   S_ACK     | cpu_ack pulse, apply any pending flush
module sdram_read_cache
  import sdram_cache_pkg::*;
#(
  parameter  int CACHE_LINES = 64,
  parameter  int DATA_BITS   = SDRAM_DATA_BITS,
  parameter  int ADDR_BITS   = SDRAM_ADDR_BITS,
  localparam int IDX_BITS    = index_bits(CACHE_LINES),
  localparam int TAG_BITS    = tag_bits(CACHE_LINES, ADDR_BITS),
  localparam int BE_BITS     = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset_i,
  input  logic                 flush_i,
  input  logic                 cpu_cs_i,
  input  logic                 cpu_read0_write1_i,
  input  logic [BE_BITS-1:0]   cpu_byteenable_i,
  input  logic [ADDR_BITS-2:0] cpu_addr_i,
  input  logic [DATA_BITS-1:0] cpu_write_data_i,
  output logic                 cpu_ack_o,
  output logic [DATA_BITS-1:0] cpu_read_data_o,
  output logic                 busy_o,
  output logic                 mem_cs_o,
  output logic [BE_BITS-1:0]   mem_byteenable_o,
  output logic                 mem_read0_write1_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [DATA_BITS-1:0] mem_write_data_o,
  input  logic                 mem_ack_i,
  input  logic [DATA_BITS-1:0] mem_read_data_i
);

  state_e               state_q;
  logic [ADDR_BITS-2:0] addr_q;
  logic                 dir_q;
  logic [BE_BITS-1:0]   be_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 hit_q;
  logic                 flush_pending_q;
  logic                 cpu_ack_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 mem_cs_q;
  logic [BE_BITS-1:0]   mem_be_q;
  logic                 mem_dir_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_q;

  logic [IDX_BITS-1:0]  req_index;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 line_valid;
  logic [TAG_BITS-1:0]  line_tag;
  logic [DATA_BITS-1:0] line_data;
  logic                 lookup_hit;

  logic                 clear_all_d;
  logic                 arr_wr_en_d;
  logic                 arr_set_valid_d;
  logic [BE_BITS-1:0]   arr_be_d;
  logic [DATA_BITS-1:0] arr_data_d;

  assign req_index  = addr_q[IDX_BITS-1:0];
  assign req_tag    = addr_q[ADDR_BITS-2:IDX_BITS];
  assign lookup_hit = line_valid && (line_tag == req_tag);

  // Fill on refill ack, merge on a write that hit; a pending flush is applied
  // on the way out of S_ACK, after the fill, so the filled line ends invalid.
  always_comb begin
    clear_all_d     = sync_reset_i
                    || (flush_i && state_q == S_IDLE)
                    || (state_q == S_ACK && (flush_pending_q || flush_i));
    arr_wr_en_d     = 1'b0;
    arr_set_valid_d = 1'b0;
    arr_be_d        = be_q;
    arr_data_d      = wdata_q;
    if (!sync_reset_i) begin
      if (state_q == S_WAIT_RD && mem_ack_i) begin
        arr_wr_en_d     = 1'b1;
        arr_set_valid_d = 1'b1;
        arr_be_d        = '1;
        arr_data_d      = mem_read_data_i;
      end else if (state_q == S_WR && hit_q) begin
        arr_wr_en_d     = 1'b1;
      end
    end
  end

  sdram_cache_line_array #(
    .LINES     (CACHE_LINES),
    .DATA_BITS (DATA_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_lines (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear_all_i    (clear_all_d),
    .rd_index_i     (req_index),
    .rd_valid_o     (line_valid),
    .rd_tag_o       (line_tag),
    .rd_data_o      (line_data),
    .wr_en_i        (arr_wr_en_d),
    .wr_set_valid_i (arr_set_valid_d),
    .wr_index_i     (req_index),
    .wr_tag_i       (req_tag),
    .wr_be_i        (arr_be_d),
    .wr_data_i      (arr_data_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      dir_q           <= 1'b0;
      be_q            <= '0;
      wdata_q         <= '0;
      hit_q           <= 1'b0;
      flush_pending_q <= 1'b0;
      cpu_ack_q       <= 1'b0;
      rdata_q         <= '0;
      mem_cs_q        <= 1'b0;
      mem_be_q        <= '0;
      mem_dir_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else if (sync_reset_i) begin
      state_q         <= S_IDLE;
      flush_pending_q <= 1'b0;
      cpu_ack_q       <= 1'b0;
      mem_cs_q        <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      mem_cs_q  <= 1'b0;
      if (state_q == S_ACK) begin
        flush_pending_q <= 1'b0;
      end else if (flush_i && state_q != S_IDLE) begin
        flush_pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (cpu_cs_i) begin
            addr_q  <= cpu_addr_i;
            dir_q   <= cpu_read0_write1_i;
            be_q    <= cpu_byteenable_i;
            wdata_q <= cpu_write_data_i;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          if (dir_q) begin
            mem_cs_q    <= 1'b1;
            mem_dir_q   <= 1'b1;
            mem_be_q    <= be_q;
            mem_addr_q  <= {addr_q, 1'b0};
            mem_wdata_q <= wdata_q;
            state_q     <= S_WR;
          end else if (lookup_hit) begin
            rdata_q   <= line_data;
            cpu_ack_q <= 1'b1;
            state_q   <= S_ACK;
          end else begin
            mem_cs_q    <= 1'b1;
            mem_dir_q   <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= {addr_q, 1'b0};
            mem_wdata_q <= wdata_q;
            state_q     <= S_MISS;
          end
        end
        S_MISS:  state_q <= S_WAIT_RD;
        S_WR:    state_q <= S_WAIT_WR;
        S_WAIT_RD: begin
          if (mem_ack_i) begin
            rdata_q   <= mem_read_data_i;
            cpu_ack_q <= 1'b1;
            state_q   <= S_ACK;
          end
        end
        S_WAIT_WR: begin
          if (mem_ack_i) begin
            cpu_ack_q <= 1'b1;
            state_q   <= S_ACK;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o             = (state_q != S_IDLE);
  assign cpu_ack_o          = cpu_ack_q;
  assign cpu_read_data_o    = rdata_q;
  assign mem_cs_o           = mem_cs_q;
  assign mem_byteenable_o   = mem_be_q;
  assign mem_read0_write1_o = mem_dir_q;
  assign mem_addr_o         = mem_addr_q;
  assign mem_write_data_o   = mem_wdata_q;

endmodule

// File: tb/tb_sdram_read_cache.sv
// Directed and random accesses against a direct-mapped cache model and a word
// memory model that also plays the sdram_controller side.
module tb_sdram_read_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic        flush;
  logic        cpu_cs;
  logic        cpu_rw;
  logic [3:0]  cpu_be;
  logic [22:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        busy;
  logic        mem_cs;
  logic [3:0]  mem_be;
  logic        mem_rw;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  bit          mvalid [64];
  logic [22:0] mline  [64];
  logic [31:0] smem   [logic [22:0]];

  always #5 clk = ~clk;

  sdram_read_cache dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sync_reset_i       (sync_reset),
    .flush_i            (flush),
    .cpu_cs_i           (cpu_cs),
    .cpu_read0_write1_i (cpu_rw),
    .cpu_byteenable_i   (cpu_be),
    .cpu_addr_i         (cpu_addr),
    .cpu_write_data_i   (cpu_wdata),
    .cpu_ack_o          (cpu_ack),
    .cpu_read_data_o    (cpu_rdata),
    .busy_o             (busy),
    .mem_cs_o           (mem_cs),
    .mem_byteenable_o   (mem_be),
    .mem_read0_write1_o (mem_rw),
    .mem_addr_o         (mem_addr),
    .mem_write_data_o   (mem_wdata),
    .mem_ack_i          (mem_ack),
    .mem_read_data_i    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [22:0] a);
    if (smem.exists(a)) return smem[a];
    return ({9'h0, a} * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic inv_all();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // flush_at: -1 none, 0 together with cpu_cs, >0 cycle while busy.
  // spur_at / srst_at: cycle for a stray cpu_cs / sync_reset pulse, 0 = none.
  task automatic access(input bit wr, input logic [22:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int ack_dly, input int flush_at,
                        input int spur_at, input int srst_at);
    int          idx;
    bit          exp_hit;
    int          mem_seen, ack_seen, ack_cyc, mcs_cyc, mack_cyc;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    idx = int'(a[5:0]);
    if (flush_at == 0) inv_all();
    exp_hit  = mvalid[idx] && (mline[idx] == a);
    exp_rd   = mem_val(a);
    exp_be   = wr ? be : 4'hF;
    mem_seen = 0; ack_seen = 0; ack_cyc = -1; mcs_cyc = -1; mack_cyc = -1;
    @(negedge clk);
    cpu_cs = 1'b1; cpu_rw = wr; cpu_be = be; cpu_addr = a; cpu_wdata = wd;
    flush = (flush_at == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_cs === 1'b1) begin
        mem_seen++;
        if (mem_seen == 1) begin
          mcs_cyc  = c;
          mack_cyc = c + ack_dly;
          chk("mem_addr", 32'(mem_addr), 32'({a, 1'b0}));
          chk("mem_be", 32'(mem_be), 32'(exp_be));
          chk("mem_dir", 32'(mem_rw), 32'(wr));
          if (wr) chk("mem_wdata", mem_wdata, wd);
        end
      end
      if (c == mack_cyc && c > mcs_cyc) begin
        chk("mem_addr_hold", 32'(mem_addr), 32'({a, 1'b0}));
        chk("mem_be_hold", 32'(mem_be), 32'(exp_be));
      end
      if (cpu_ack === 1'b1) begin
        ack_seen++;
        if (ack_seen == 1) begin
          ack_cyc = c;
          if (!wr) chk("cpu_rdata", cpu_rdata, exp_rd);
        end
      end
      if (ack_cyc > 0 && c == ack_cyc + 1) chk("busy_after_ack", 32'(busy), 32'd0);
      if (srst_at > 0 && c == srst_at + 1) begin
        chk("busy_after_srst", 32'(busy), 32'd0);
        chk("ack_after_srst", 32'(cpu_ack), 32'd0);
      end
      if (srst_at > 0 && c >= srst_at) mack_cyc = -1;
      cpu_cs = 1'b0; cpu_addr = a; cpu_rw = wr; flush = 1'b0;
      sync_reset = 1'b0; mem_ack = 1'b0;
      if (c == spur_at) begin
        cpu_cs = 1'b1; cpu_addr = a ^ 23'h15; cpu_rw = ~wr;
      end
      if (c == flush_at) flush = 1'b1;
      if (c == srst_at) sync_reset = 1'b1;
      if (c == mack_cyc) begin
        mem_ack   = 1'b1;
        mem_rdata = wr ? $urandom : exp_rd;
      end
      if (ack_cyc > 0 && c >= ack_cyc + 2) break;
      if (srst_at > 0 && c >= srst_at + 6) break;
    end
    if (srst_at > 0) begin
      chk("srst_no_ack", 32'(ack_seen), 32'd0);
      inv_all();
    end else begin
      chk("ack_count", 32'(ack_seen), 32'd1);
      chk("mem_cs_count", 32'(mem_seen), (!wr && exp_hit) ? 32'd0 : 32'd1);
      if (!wr && exp_hit) chk("hit_latency", 32'(ack_cyc), 32'd2);
      else                chk("miss_latency", 32'(ack_cyc), 32'(mack_cyc + 1));
      if (wr) smem[a] = merge(mem_val(a), wd, be);
      else if (!exp_hit) begin
        mvalid[idx] = 1'b1;
        mline[idx]  = a;
      end
      if (flush_at > 0) inv_all();
    end
  endtask

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; flush = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b0;
    cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    inv_all();
    smem[23'h000010] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_dir", 32'(mem_rw), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    reset_n = 1'b1;

    // refill, hit, write-hit merge
    access(1'b0, 23'h000010, 4'hF, 32'h0, 2, -1, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b1, 23'h000010, 4'b0011, 32'h00001234, 1, -1, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, -1, 0, 0);
    // conflict misses and write miss without allocate
    access(1'b0, 23'h000050, 4'hF, 32'h0, 3, -1, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b0, 23'h000050, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b1, 23'h000090, 4'hF, 32'hCAFEF00D, 2, -1, 0, 0);
    access(1'b0, 23'h000050, 4'hF, 32'h0, 1, -1, 0, 0);
    // flush while busy, flush together with cpu_cs
    access(1'b0, 23'h000010, 4'hF, 32'h0, 3, 3, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 1, 0, 0, 0);
    // sync_reset in S_WAIT_RD, then stray cpu_cs while busy
    access(1'b0, 23'h000050, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b0, 23'h000020, 4'hF, 32'h0, 6, -1, 0, 4);
    access(1'b0, 23'h000050, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b0, 23'h000050, 4'hF, 32'h0, 1, -1, 2, 0);
    access(1'b0, 23'h000010, 4'hF, 32'h0, 2, -1, 2, 0);
    // address wrap at the top of the word space
    access(1'b0, 23'h7FFFFF, 4'hF, 32'h0, 1, -1, 0, 0);
    access(1'b1, 23'h7FFFFF, 4'b1000, 32'h5A000000, 1, -1, 0, 0);
    access(1'b0, 23'h7FFFFF, 4'hF, 32'h0, 1, -1, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [22:0] ra;
      logic [3:0]  rbe;
      bit          rwr;
      int          fa, sp;
      ra  = {19'($urandom_range(0, 3)), 4'($urandom_range(0, 7))};
      if ($urandom_range(0, 19) == 0) ra = 23'h7FFFFF;
      rwr = ($urandom_range(0, 9) < 3);
      rbe = 4'($urandom_range(1, 15));
      fa  = -1;
      case ($urandom_range(0, 11))
        0: fa = 0;
        1: fa = 3;
        default: fa = -1;
      endcase
      sp  = ($urandom_range(0, 7) == 0) ? 2 : 0;
      access(rwr, ra, rbe, $urandom, int'($urandom_range(1, 3)), fa, sp, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
